// File: rtl/dff_reg_write_arbiter_if.sv
// Bus between write requesters and the shared holding-register arbiter.
// The arbiter takes the slave modport; a requester-side block or bench takes master.
interface dff_reg_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) ();
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                      flush;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         q;
  logic                      q_valid;
  logic                      busy;
  logic [ID_W-1:0]           last_id;

  modport master (
    output flush, req, wdata,
    input  gnt, q, q_valid, busy, last_id
  );

  modport slave (
    input  flush, req, wdata,
    output gnt, q, q_valid, busy, last_id
  );
endinterface

// File: rtl/dff_reg_write_arbiter.sv
// Round-robin arbiter sharing one DATA_W holding register among NUM_REQ writers,
// with a HOLD_CYC guard after each write. Define FIXED_PRIO_EN for lowest-index-wins priority.
module dff_reg_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  dff_reg_write_arbiter_if.slave  bus
);
  localparam int          ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR   = NUM_REQ;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t            state, state_nxt;
  logic [3:0]        hold_cnt, hold_cnt_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_nxt, winner;
  logic              win_vld, grant;
  logic [DATA_W-1:0] wsel;
  int unsigned       idx;

  // Scan from rr_ptr upward with wrap; rr_ptr is pinned at 0 in fixed-priority builds.
  always_comb begin
    win_vld = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(rr_ptr) + k) % NR;
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    wsel = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (ID_W'(k) == winner) wsel = bus.wdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
`ifdef FIXED_PRIO_EN
    rr_nxt = '0;
`else
    rr_nxt = (winner == ID_W'(NR - 1)) ? '0 : winner + 1'b1;
`endif
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    grant        = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          grant     = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        state_nxt    = HOLD;
        hold_cnt_nxt = 4'(HOLD_CYC - 1);
      end
      HOLD: begin
        if (hold_cnt == '0) state_nxt = IDLE;
        else                hold_cnt_nxt = hold_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      state_nxt = IDLE;
      grant     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // flush clears the register but keeps the round-robin pointer and last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
      bus.gnt     <= '0;
      bus.last_id <= '0;
      rr_ptr      <= '0;
    end else begin
      bus.gnt <= '0;
      if (bus.flush) begin
        bus.q       <= '0;
        bus.q_valid <= 1'b0;
      end else if (grant) begin
        bus.q       <= wsel;
        bus.q_valid <= 1'b1;
        bus.last_id <= winner;
        bus.gnt     <= NUM_REQ'(1) << winner;
        rr_ptr      <= rr_nxt;
      end
    end
  end

  assign bus.busy = (state != IDLE);
endmodule
